// File: rtl/demux1to2_5bits.sv
// ---------------------------------------------------------------------------
// demux1to2_5bits
//
// Buffered 1-to-2 demultiplexer. A single time-multiplexed stream arrives
// through a valid/ready handshake and each beat is steered into lane A or
// lane B, where it waits in a small per-lane FIFO for its own consumer.
// The lane is chosen per beat by in_sel, or by an internal alternating
// state machine when auto_mode is set.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake, in_data carries the beat
//   in_sel                lane select in manual mode (0 = A, 1 = B)
//   auto_mode             1 = alternate A,B,A,B... and ignore in_sel
//   next_lane             lane the next accepted beat takes in auto mode
//   a_valid/a_ready       lane A output handshake, a_data is the head beat
//   a_count               lane A occupancy, 0..DEPTH
//   b_valid/b_ready       lane B output handshake, b_data is the head beat
//   b_count               lane B occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module demux1to2_5bits #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             auto_mode,
   output logic             next_lane,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic [CW-1:0]    a_count,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [CW-1:0]    b_count
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } lane_state_t;

   lane_state_t state_q, state_d;

   logic [WIDTH-1:0] a_mem_q [DEPTH];
   logic [WIDTH-1:0] a_mem_d [DEPTH];
   logic [WIDTH-1:0] b_mem_q [DEPTH];
   logic [WIDTH-1:0] b_mem_d [DEPTH];
   logic [PW-1:0]    a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PW-1:0]    b_wr_q, b_wr_d, b_rd_q, b_rd_d;
   logic [CW-1:0]    a_count_q, a_count_d;
   logic [CW-1:0]    b_count_q, b_count_d;

   logic target_lane;
   logic a_full, b_full;
   logic accept;
   logic a_push, b_push, a_pop, b_pop;

   // Handshake decode. in_ready looks only at the target lane's current
   // occupancy, so a full lane refuses a beat even while its consumer pops.
   always_comb begin
      target_lane = auto_mode ? next_lane : in_sel;
      a_full      = (a_count_q == CW'(DEPTH));
      b_full      = (b_count_q == CW'(DEPTH));
      in_ready    = target_lane ? !b_full : !a_full;
      accept      = in_valid && in_ready;
      a_push      = accept && !target_lane;
      b_push      = accept &&  target_lane;
      a_pop       = a_valid && a_ready;
      b_pop       = b_valid && b_ready;
   end

   // Auto-mode lane alternation: advance only on an accepted beat taken
   // while auto_mode is high, otherwise hold so manual phases and stalls
   // leave the sequence where it was.
   always_comb begin
      state_d = state_q;
      if (auto_mode && accept) begin
         state_d = (state_q == LANE_A) ? LANE_B : LANE_A;
      end
   end

   // Lane A FIFO next state. Pointers wrap naturally because DEPTH is a
   // power of two; simultaneous push and pop leaves the count unchanged.
   always_comb begin
      a_mem_d   = a_mem_q;
      a_wr_d    = a_wr_q;
      a_rd_d    = a_rd_q;
      a_count_d = a_count_q;
      if (a_push) begin
         a_mem_d[a_wr_q] = in_data;
         a_wr_d          = a_wr_q + PW'(1);
      end
      if (a_pop) begin
         a_rd_d = a_rd_q + PW'(1);
      end
      case ({a_push, a_pop})
         2'b10:   a_count_d = a_count_q + CW'(1);
         2'b01:   a_count_d = a_count_q - CW'(1);
         default: a_count_d = a_count_q;
      endcase
   end

   // Lane B FIFO next state, mirror of lane A.
   always_comb begin
      b_mem_d   = b_mem_q;
      b_wr_d    = b_wr_q;
      b_rd_d    = b_rd_q;
      b_count_d = b_count_q;
      if (b_push) begin
         b_mem_d[b_wr_q] = in_data;
         b_wr_d          = b_wr_q + PW'(1);
      end
      if (b_pop) begin
         b_rd_d = b_rd_q + PW'(1);
      end
      case ({b_push, b_pop})
         2'b10:   b_count_d = b_count_q + CW'(1);
         2'b01:   b_count_d = b_count_q - CW'(1);
         default: b_count_d = b_count_q;
      endcase
   end

   // State registers. Reset discards everything buffered and returns the
   // alternation to lane A.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= LANE_A;
         a_wr_q    <= '0;
         a_rd_q    <= '0;
         a_count_q <= '0;
         b_wr_q    <= '0;
         b_rd_q    <= '0;
         b_count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            a_mem_q[i] <= '0;
            b_mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         a_wr_q    <= a_wr_d;
         a_rd_q    <= a_rd_d;
         a_count_q <= a_count_d;
         b_wr_q    <= b_wr_d;
         b_rd_q    <= b_rd_d;
         b_count_q <= b_count_d;
         for (int i = 0; i < DEPTH; i++) begin
            a_mem_q[i] <= a_mem_d[i];
            b_mem_q[i] <= b_mem_d[i];
         end
      end
   end

   // Registered-state outputs; head data reads as zero on an empty lane.
   always_comb begin
      next_lane = (state_q == LANE_B);
      a_valid   = (a_count_q != '0);
      b_valid   = (b_count_q != '0);
      a_data    = a_valid ? a_mem_q[a_rd_q] : '0;
      b_data    = b_valid ? b_mem_q[b_rd_q] : '0;
      a_count   = a_count_q;
      b_count   = b_count_q;
   end

endmodule

// File: tb/tb_demux1to2_5bits.sv
// ---------------------------------------------------------------------------
// tb_demux1to2_5bits
//
// Self-checking bench for demux1to2_5bits. A queue-based reference model
// (one queue per lane plus an alternation bit) predicts every output each
// cycle; directed sequences are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_demux1to2_5bits;

   localparam int WIDTH = 5;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clock;
   logic             reset;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inData;
   logic             inSel;
   logic             autoMode;
   logic             nextLane;
   logic             aValid, aReady, bValid, bReady;
   logic [WIDTH-1:0] aData, bData;
   logic [CW-1:0]    aCount, bCount;

   int errorCount = 0;
   int checkCount = 0;

   logic [WIDTH-1:0] modelA[$];
   logic [WIDTH-1:0] modelB[$];
   logic             modelLane  = 1'b0;
   logic             modelKnown = 1'b0;

   demux1to2_5bits #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_data   (inData),
      .in_sel    (inSel),
      .auto_mode (autoMode),
      .next_lane (nextLane),
      .a_valid   (aValid),
      .a_ready   (aReady),
      .a_data    (aData),
      .a_count   (aCount),
      .b_valid   (bValid),
      .b_ready   (bReady),
      .b_data    (bData),
      .b_count   (bCount)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compare every output against the model's view of the current cycle.
   task automatic checkAll();
      logic             tgt;
      logic             tgtFull;
      logic [WIDTH-1:0] expA, expB;
      tgt     = autoMode ? modelLane : inSel;
      tgtFull = tgt ? (modelB.size() == DEPTH) : (modelA.size() == DEPTH);
      expA    = (modelA.size() > 0) ? modelA[0] : '0;
      expB    = (modelB.size() > 0) ? modelB[0] : '0;
      checkOutput("a_valid",   32'(aValid),   32'(modelA.size() > 0));
      checkOutput("a_data",    32'(aData),    32'(expA));
      checkOutput("a_count",   32'(aCount),   32'(modelA.size()));
      checkOutput("b_valid",   32'(bValid),   32'(modelB.size() > 0));
      checkOutput("b_data",    32'(bData),    32'(expB));
      checkOutput("b_count",   32'(bCount),   32'(modelB.size()));
      checkOutput("next_lane", 32'(nextLane), 32'(modelLane));
      checkOutput("in_ready",  32'(inReady),  32'(!tgtFull));
   endtask

   // Drive one cycle of inputs just after the falling edge, check outputs,
   // then advance the model across the next rising edge.
   task automatic applyStimulus(input logic rst, input logic v, input logic sel,
                                input logic am, input logic [WIDTH-1:0] d,
                                input logic ar, input logic br);
      logic tgt, acc, popA, popB;
      reset    = rst;
      inValid  = v;
      inSel    = sel;
      autoMode = am;
      inData   = d;
      aReady   = ar;
      bReady   = br;
      #1;
      if (modelKnown) checkAll();
      tgt  = am ? modelLane : sel;
      acc  = v && (tgt ? (modelB.size() < DEPTH) : (modelA.size() < DEPTH));
      popA = ar && (modelA.size() > 0);
      popB = br && (modelB.size() > 0);
      @(posedge clock);
      if (rst) begin
         modelA.delete();
         modelB.delete();
         modelLane  = 1'b0;
         modelKnown = 1'b1;
      end else begin
         if (popA) void'(modelA.pop_front());
         if (popB) void'(modelB.pop_front());
         if (acc) begin
            if (tgt) modelB.push_back(d);
            else     modelA.push_back(d);
            if (am) modelLane = !modelLane;
         end
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; inValid = 1'b0; inSel = 1'b0; autoMode = 1'b0;
      inData = '0; aReady = 1'b0; bReady = 1'b0;
      @(negedge clock);

      // Reset, then one beat per lane with both consumers ready.
      applyStimulus(1, 0, 0, 0, 5'h00, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h01, 1, 1);
      applyStimulus(0, 1, 1, 0, 5'h02, 1, 1);
      applyStimulus(0, 0, 0, 0, 5'h00, 1, 1);
      applyStimulus(0, 0, 0, 0, 5'h00, 1, 1);

      // Lane A backpressure: third beat held until the lane drains.
      applyStimulus(0, 1, 0, 0, 5'h03, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h04, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h05, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h05, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h05, 1, 0);
      applyStimulus(0, 1, 0, 0, 5'h05, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 5'h00, 1, 0);

      // Auto mode alternation, with lane B stalled full mid-sequence.
      applyStimulus(0, 1, 1, 1, 5'h10, 1, 0);
      applyStimulus(0, 1, 0, 1, 5'h11, 1, 0);
      applyStimulus(0, 1, 1, 1, 5'h12, 1, 0);
      applyStimulus(0, 1, 0, 1, 5'h13, 1, 0);
      applyStimulus(0, 1, 1, 1, 5'h14, 1, 0);
      applyStimulus(0, 1, 0, 1, 5'h15, 1, 0);
      applyStimulus(0, 1, 0, 1, 5'h15, 1, 0);
      applyStimulus(0, 1, 0, 1, 5'h15, 1, 1);
      applyStimulus(0, 1, 0, 1, 5'h15, 1, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 5'h00, 1, 1);

      // Same-cycle push and pop on lane B at count 1, then dual pops.
      applyStimulus(0, 1, 1, 0, 5'h06, 0, 0);
      applyStimulus(0, 1, 1, 0, 5'h07, 0, 1);
      applyStimulus(0, 1, 0, 0, 5'h08, 0, 0);
      applyStimulus(0, 0, 0, 0, 5'h00, 1, 1);
      applyStimulus(0, 0, 0, 0, 5'h00, 1, 1);

      // Lane A full, lane B empty: in_sel picks which readiness is seen.
      applyStimulus(0, 1, 0, 0, 5'h09, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h0a, 0, 0);
      applyStimulus(0, 1, 1, 0, 5'h0b, 0, 0);
      applyStimulus(0, 1, 0, 0, 5'h0c, 0, 0);

      // Reset with both lanes holding data, with a beat offered meanwhile.
      applyStimulus(1, 1, 1, 0, 5'h1f, 0, 0);
      applyStimulus(0, 0, 0, 1, 5'h00, 0, 0);

      // Randomized traffic with occasional resets and mode changes.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), WIDTH'($urandom),
                       ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      end
      applyStimulus(0, 0, 0, 0, 5'h00, 1, 1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
